// File: rtl/slave_port.sv
// slave_port: responder end of the serial system bus.
// Receives an LSB-first memory address (and write data for writes).
// Issues one parallel request to the attached slave memory. For reads,
// it shifts the returned word back out LSB-first with svalid.
// Optional macro SLAVE_PORT_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_CYCLES consecutive cycles with mvalid low.
module slave_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata,
  input  logic                  drvalid
);

  localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, RADDR, WDATA, MEMREQ, MEMWAIT, RDATA} state_t;

  state_t                state_reg, state_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  mode_reg, mode_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  srdata_reg, srdata_next;
  logic                  svalid_reg, svalid_next;
  logic                  addr_we, wdata_we;

`ifdef SLAVE_PORT_TIMEOUT_EN
  localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_WIDTH-1:0] stall_reg, stall_next;
`endif

  // Serial capture: the bit addressed by the counter takes swdata.
  // All other bits hold their value.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_bit
      assign addr_next[gi] = (addr_we && cnt_reg == CNT_WIDTH'(gi)) ? swdata : addr_reg[gi];
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_wdata_bit
      assign wdata_next[gi] = (wdata_we && cnt_reg == CNT_WIDTH'(gi)) ? swdata : wdata_reg[gi];
    end
  endgenerate

  // Next-state logic: frame sequencing, device handshake and read shift-out.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    rdata_next  = rdata_reg;
    srdata_next = srdata_reg;
    svalid_next = svalid_reg;
    addr_we     = 1'b0;
    wdata_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mvalid) begin
          addr_we   = 1'b1;
          mode_next = smode;
          if (ADDR_WIDTH == 1) begin
            cnt_next   = '0;
            state_next = smode ? WDATA : MEMREQ;
          end else begin
            cnt_next   = CNT_WIDTH'(1);
            state_next = RADDR;
          end
        end
      end
      RADDR: begin
        if (mvalid) begin
          addr_we = 1'b1;
          if (cnt_reg == ADDR_LAST) begin
            cnt_next   = '0;
            state_next = mode_reg ? WDATA : MEMREQ;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WDATA: begin
        if (mvalid) begin
          wdata_we = 1'b1;
          if (cnt_reg == DATA_LAST) begin
            cnt_next   = '0;
            state_next = MEMREQ;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      MEMREQ: begin
        if (dready) state_next = mode_reg ? IDLE : MEMWAIT;
      end
      MEMWAIT: begin
        // Bit 0 goes out straight away; the rest are shifted down to bit 0.
        if (drvalid) begin
          rdata_next  = drdata;
          srdata_next = drdata[0];
          svalid_next = 1'b1;
          cnt_next    = '0;
          state_next  = RDATA;
        end
      end
      RDATA: begin
        if (cnt_reg == DATA_LAST) begin
          srdata_next = 1'b0;
          svalid_next = 1'b0;
          cnt_next    = '0;
          state_next  = IDLE;
        end else begin
          rdata_next  = rdata_reg >> 1;
          srdata_next = rdata_next[0];
          cnt_next    = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef SLAVE_PORT_TIMEOUT_EN
    // Drop a partial frame once the master has been silent too long.
    stall_next = '0;
    if (state_reg == RADDR || state_reg == WDATA) begin
      if (!mvalid) begin
        stall_next = stall_reg + 1'b1;
        if (stall_next == STALL_WIDTH'(TIMEOUT_CYCLES)) begin
          stall_next = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      srdata_reg <= 1'b0;
      svalid_reg <= 1'b0;
`ifdef SLAVE_PORT_TIMEOUT_EN
      stall_reg  <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      srdata_reg <= srdata_next;
      svalid_reg <= svalid_next;
`ifdef SLAVE_PORT_TIMEOUT_EN
      stall_reg  <= stall_next;
`endif
    end
  end

  assign sready = (state_reg == IDLE);
  assign dvalid = (state_reg == MEMREQ);
  assign daddr  = addr_reg;
  assign dwdata = wdata_reg;
  assign dmode  = mode_reg;
  assign srdata = srdata_reg;
  assign svalid = svalid_reg;

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Responder end of the serial system bus; one instance per slave device.
- Deserialises the LSB-first memory address and, for writes, the write data arriving from the bus.
- Issues one parallel request to the attached slave memory and, for reads, serialises the returned data LSB-first back to the bus with svalid.
- The address decoder strips the slave-device-address bits and forwards only memory-address and write-data bits to this port.

Parameters:
- ADDR_WIDTH, 12: slave memory address width; bits received per frame address phase.
- DATA_WIDTH, 8: data word width.
- TIMEOUT_CYCLES, 8: stall limit; used only with SLAVE_PORT_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- swdata  in  1  serial address/write-data bit from the bus (master mwdata).
- smode  in  1  0 = read, 1 = write; valid while a frame is in progress.
- mvalid  in  1  swdata bit valid this cycle.
- srdata  out  1  serial read-data bit to the bus (master mrdata).
- svalid  out  1  srdata bit valid.
- sready  out  1  port idle; consumed by the address decoder before it acks.
- daddr  out  ADDR_WIDTH  memory address to the slave device.
- dwdata  out  DATA_WIDTH  write data to the slave device.
- dmode  out  1  0 = read, 1 = write.
- dvalid  out  1  request valid to the slave device.
- dready  in  1  slave device accepts the request.
- drdata  in  DATA_WIDTH  read data from the slave device.
- drvalid  in  1  drdata valid; single-cycle pulse.

Behaviour:
- Reset: state IDLE, counter 0, all internal regs 0. Outputs: srdata 0, svalid 0, sready 1, daddr 0, dwdata 0, dmode 0, dvalid 0. Reset asserted mid-frame abandons the frame with no device access.
- States: IDLE, RADDR, WDATA, MEMREQ, MEMWAIT, RDATA.
- IDLE:
  - sready = 1.
  - On mvalid: addr[0] <= swdata, mode <= smode, counter <= 1, go to RADDR. If ADDR_WIDTH == 1, go straight to WDATA or MEMREQ per smode.
- RADDR:
  - Each mvalid cycle: addr[counter] <= swdata.
  - At counter == ADDR_WIDTH-1, reset counter to 0 and go to WDATA (mode = 1) or MEMREQ (mode = 0).
  - Cycles with mvalid low hold state and counter (stall).
- WDATA:
  - Each mvalid cycle: wdata[counter] <= swdata.
  - At counter == DATA_WIDTH-1, go to MEMREQ. Stalls as in RADDR.
- MEMREQ:
  - dvalid = 1; daddr, dwdata, dmode stable while dvalid is high.
  - dvalid rises on the cycle after the last serial bit is sampled.
  - On dvalid && dready: drop dvalid next cycle; write goes to IDLE, read goes to MEMWAIT.
- MEMWAIT:
  - On drvalid: rdata <= drdata, counter <= 0, go to RDATA.
  - drvalid in the same cycle as the dready handshake is not accepted; the device must return data no earlier than the following cycle.
- RDATA:
  - svalid = 1 and srdata = rdata[counter] for DATA_WIDTH consecutive cycles, LSB first, registered outputs.
  - After bit DATA_WIDTH-1, svalid drops and the port returns to IDLE.
- sready = 1 only in IDLE.
- mvalid outside IDLE/RADDR/WDATA is ignored; it does not start a new frame.
- drvalid outside MEMWAIT is ignored.
- The counter is wide enough for max(ADDR_WIDTH, DATA_WIDTH) and never wraps mid-phase.
- Back-to-back frames: a new frame may start on the first IDLE cycle.

Optional Feature:
- Macro: SLAVE_PORT_TIMEOUT_EN.
- Defined: in RADDR and WDATA, a stall counter increments on each mvalid-low cycle and clears on each mvalid-high cycle. When it reaches TIMEOUT_CYCLES, the port returns to IDLE next cycle, discards the partial frame and issues no device request.
- Not defined: no stall counter; the port waits indefinitely for the remaining bits.

Test Plan:
- Write frame, addr 0x5A3, data 0xC6, smode 1, no gaps, dready tied 1 -> single dvalid pulse with daddr 0x5A3, dwdata 0xC6, dmode 1, one cycle after the 20th bit; sready high next cycle.
- Read frame, addr 0x0F0; device returns drdata 0x81 three cycles after the handshake -> dmode 0, daddr 0x0F0; svalid high 8 consecutive cycles; srdata sequence 1,0,0,0,0,0,0,1.
- Write 0x3FF/0x55 with mvalid low 2 cycles after each of address bits 3 and 11 -> same request captured as without gaps; no extra dvalid.
- dready held low 5 cycles in MEMREQ -> dvalid high and daddr/dwdata/dmode unchanged all 5 cycles; dvalid drops the cycle after dready rises.
- rst pulsed after 6 address bits, then a full read of 0x001 returning 0xFF -> all outputs at reset values, no dvalid for the aborted frame; second frame correct, srdata all ones.
- SLAVE_PORT_TIMEOUT_EN defined: stop mvalid after 5 address bits for 8 cycles -> IDLE, sready 1, no dvalid; following write 0x123/0xA0 decoded correctly.
